// File: rtl/p405s_isocm_pkg.sv
// Shared widths, FSM states and buffer-entry type for the ISOCM instruction fetcher.
// Pure declarations: no latency, no flow control.
package p405s_isocm_pkg;

    localparam int ISOCM_AW = 30;
    localparam int ISOCM_DW = 64;
    localparam int ISOCM_IW = 32;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_ERR
    } fetch_state_t;

    typedef struct packed {
        logic [0:ISOCM_AW-1] addr;
        logic [0:ISOCM_IW-1] word;
    } ins_entry_t;

    // Start of the next doubleword line; wraps modulo 2^30.
    function automatic logic [0:ISOCM_AW-1] next_line(input logic [0:ISOCM_AW-1] pc);
        return {pc[0:ISOCM_AW-2] + (ISOCM_AW-1)'(1), 1'b0};
    endfunction

endpackage

// File: rtl/p405s_isocm_fetch_fifo.sv
// Instruction buffer of {addr,word} entries; up to two pushes and one pop per cycle.
// Push visible at head one cycle later; the caller must not push beyond free_cnt.
module p405s_isocm_fetch_fifo
    import p405s_isocm_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_lo,
    input  ins_entry_t       push_lo_dat,
    input  logic             push_hi,
    input  ins_entry_t       push_hi_dat,
    input  logic             pop,
    output logic             empty,
    output ins_entry_t       head_dat,
    output logic [PTR_W:0]   free_cnt
);

    ins_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] hi_ptr;
    logic [PTR_W:0]   count;
    logic             pop_eff;

    assign empty    = (count == '0);
    assign pop_eff  = pop & ~empty;
    // The high word lands just after the low word when both arrive together.
    assign hi_ptr   = wr_ptr + PTR_W'(push_lo);
    assign head_dat = mem[rd_ptr];
    assign free_cnt = (PTR_W+1)'(DEPTH) - count;

    always_ff @(posedge clk) begin
        if (push_lo) mem[wr_ptr] <= push_lo_dat;
        if (push_hi) mem[hi_ptr] <= push_hi_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_lo) + PTR_W'(push_hi);
            rd_ptr <= rd_ptr + PTR_W'(pop_eff);
            count  <= count + (PTR_W+1)'(push_lo) + (PTR_W+1)'(push_hi)
                            - (PTR_W+1)'(pop_eff);
        end
    end

endmodule

// File: rtl/p405s_isocm_fetcher.sv
// Sequential ISOCM instruction fetcher: one request in flight, first word visible 3 cycles after start.
// Requests stall until two buffer slots are free; perf counters exist only with ISOCM_FETCH_PERF_EN.
module p405s_isocm_fetcher
    import p405s_isocm_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned HOLD_TIMEOUT = 15
) (
    input  logic                SystemClock,
    input  logic                isocm_if_reset_n,
    input  logic                fetch_start,
    input  logic                fetch_redirect,
    input  logic [0:ISOCM_AW-1] fetch_addr,
    input  logic                ins_pop,
    output logic                ins_valid,
    output logic [0:ISOCM_IW-1] ins_data,
    output logic [0:ISOCM_AW-1] ins_addr,
    output logic                fetch_err,
    output logic                C405_isocmReqPending,
    output logic                C405_isocmIcuReady,
    output logic                C405_isocmXlateValid,
    output logic                C405_isocmAbort,
    output logic [0:ISOCM_AW-1] C405_isocmABus,
    output logic                C405_isocmContextSync,
    output logic                C405_isocmU0Attr,
    output logic                C405_isocmCacheable,
    input  logic                ISOCM_c405Hold,
    input  logic [0:1]          ISOCM_c405RdDValid,
    input  logic [0:ISOCM_DW-1] ISOCM_c405RdDBus,
    output logic [15:0]         perf_req_cnt,
    output logic [15:0]         perf_hold_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned HC_W  = $clog2(HOLD_TIMEOUT + 1) + 1;

    fetch_state_t        state;
    fetch_state_t        state_nxt;
    logic [0:ISOCM_AW-1] pc;
    logic [HC_W-1:0]     hold_cnt;
    logic [HC_W-1:0]     hold_cnt_nxt;
    logic                restart;
    logic                issue;
    logic                abort;
    logic                rsp_take;
    logic                err_set;
    logic                push_lo;
    logic                push_hi;
    ins_entry_t          push_lo_dat;
    ins_entry_t          push_hi_dat;
    ins_entry_t          head_dat;
    logic                fifo_empty;
    logic [PTR_W:0]      free_cnt;

    // A start outside IDLE/ERR is indistinguishable from a redirect.
    assign restart = fetch_start | fetch_redirect;

    always_ff @(posedge SystemClock or negedge isocm_if_reset_n) begin
        if (!isocm_if_reset_n) state <= FS_IDLE;
        else                   state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        issue        = 1'b0;
        abort        = 1'b0;
        rsp_take     = 1'b0;
        err_set      = 1'b0;
        hold_cnt_nxt = '0;
        if (restart) begin
            state_nxt = FS_REQ;
            abort     = (state == FS_WAIT);
        end else begin
            unique case (state)
                FS_IDLE: begin
                    state_nxt = FS_IDLE;
                end
                FS_REQ: begin
                    if (free_cnt >= (PTR_W+1)'(2)) begin
                        issue     = 1'b1;
                        state_nxt = FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (ISOCM_c405Hold) begin
                        if (hold_cnt == HC_W'(HOLD_TIMEOUT)) begin
                            abort     = 1'b1;
                            err_set   = 1'b1;
                            state_nxt = FS_ERR;
                        end else begin
                            hold_cnt_nxt = hold_cnt + HC_W'(1);
                        end
                    end else if (|ISOCM_c405RdDValid) begin
                        rsp_take  = 1'b1;
                        state_nxt = FS_REQ;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = FS_ERR;
                    end
                end
                FS_ERR: begin
                    state_nxt = FS_ERR;
                end
                default: begin
                    state_nxt = FS_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge SystemClock or negedge isocm_if_reset_n) begin
        if (!isocm_if_reset_n) begin
            pc        <= '0;
            hold_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
            if (restart)       pc <= fetch_addr;
            else if (rsp_take) pc <= next_line(pc);
            if (restart)      fetch_err <= 1'b0;
            else if (err_set) fetch_err <= 1'b1;
        end
    end

    // The even word is skipped when the fetch started on an odd address.
    assign push_lo = rsp_take & ISOCM_c405RdDValid[0] & ~pc[ISOCM_AW-1];
    assign push_hi = rsp_take & ISOCM_c405RdDValid[1];

    assign push_lo_dat = '{addr: {pc[0:ISOCM_AW-2], 1'b0},
                           word: ISOCM_c405RdDBus[0:ISOCM_IW-1]};
    assign push_hi_dat = '{addr: {pc[0:ISOCM_AW-2], 1'b1},
                           word: ISOCM_c405RdDBus[ISOCM_IW:ISOCM_DW-1]};

    p405s_isocm_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (SystemClock),
        .rst_n       (isocm_if_reset_n),
        .flush       (restart),
        .push_lo     (push_lo),
        .push_lo_dat (push_lo_dat),
        .push_hi     (push_hi),
        .push_hi_dat (push_hi_dat),
        .pop         (ins_pop),
        .empty       (fifo_empty),
        .head_dat    (head_dat),
        .free_cnt    (free_cnt)
    );

    assign ins_valid = ~fifo_empty;
    assign ins_data  = ins_valid ? head_dat.word : '0;
    assign ins_addr  = ins_valid ? head_dat.addr : '0;

    assign C405_isocmReqPending  = issue;
    assign C405_isocmIcuReady    = issue;
    assign C405_isocmXlateValid  = issue;
    assign C405_isocmAbort       = abort;
    assign C405_isocmABus        = issue ? pc : '0;
    assign C405_isocmContextSync = 1'b0;
    assign C405_isocmU0Attr      = 1'b0;
    assign C405_isocmCacheable   = 1'b0;

`ifdef ISOCM_FETCH_PERF_EN
    logic [15:0] req_cnt;
    logic [15:0] hold_evt_cnt;

    always_ff @(posedge SystemClock or negedge isocm_if_reset_n) begin
        if (!isocm_if_reset_n) begin
            req_cnt      <= '0;
            hold_evt_cnt <= '0;
        end else if (fetch_start) begin
            req_cnt      <= '0;
            hold_evt_cnt <= '0;
        end else begin
            if (issue && req_cnt != 16'hFFFF) req_cnt <= req_cnt + 16'd1;
            if (state == FS_WAIT && ISOCM_c405Hold && hold_evt_cnt != 16'hFFFF)
                hold_evt_cnt <= hold_evt_cnt + 16'd1;
        end
    end

    assign perf_req_cnt  = req_cnt;
    assign perf_hold_cnt = hold_evt_cnt;
`else
    assign perf_req_cnt  = '0;
    assign perf_hold_cnt = '0;
`endif

endmodule

// File: tb/tb_p405s_isocm_fetcher.sv
// Randomized scoreboard bench for the ISOCM fetcher against a word-stream reference model.
module tb_p405s_isocm_fetcher;

    localparam int DEPTH = 4;
    localparam int HT    = 15;

    logic        clk;
    logic        rst_n;
    logic        fetch_start;
    logic        fetch_redirect;
    logic [29:0] fetch_addr;
    logic        ins_pop;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [29:0] ins_addr;
    logic        fetch_err;
    logic        req;
    logic        icu;
    logic        xlate;
    logic        abort;
    logic [29:0] abus;
    logic        ctx;
    logic        u0;
    logic        cache;
    logic        hold;
    logic [1:0]  rdv;
    logic [63:0] rdbus;
    logic [15:0] perf_req;
    logic [15:0] perf_hold;

    p405s_isocm_fetcher #(
        .FIFO_DEPTH   (DEPTH),
        .HOLD_TIMEOUT (HT)
    ) dut (
        .SystemClock           (clk),
        .isocm_if_reset_n      (rst_n),
        .fetch_start           (fetch_start),
        .fetch_redirect        (fetch_redirect),
        .fetch_addr            (fetch_addr),
        .ins_pop               (ins_pop),
        .ins_valid             (ins_valid),
        .ins_data              (ins_data),
        .ins_addr              (ins_addr),
        .fetch_err             (fetch_err),
        .C405_isocmReqPending  (req),
        .C405_isocmIcuReady    (icu),
        .C405_isocmXlateValid  (xlate),
        .C405_isocmAbort       (abort),
        .C405_isocmABus        (abus),
        .C405_isocmContextSync (ctx),
        .C405_isocmU0Attr      (u0),
        .C405_isocmCacheable   (cache),
        .ISOCM_c405Hold        (hold),
        .ISOCM_c405RdDValid    (rdv),
        .ISOCM_c405RdDBus      (rdbus),
        .perf_req_cnt          (perf_req),
        .perf_hold_cnt         (perf_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          req_seen = 0;

    // Reference model: the fetcher delivers consecutive words starting at the target.
    bit          active = 0;
    bit          outstanding = 0;
    bit          exp_err = 0;
    bit          stale = 0;
    bit          bad_rsp = 0;
    int          hold_mode = 0;
    int          hold_left = 0;
    int          hold_seen = 0;
    logic [29:0] next_addr = '0;
    logic [29:0] line = '0;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [29:0] a);
        exp_t e;
        e.a = a;
        e.d = mem_word(a);
        q.push_back(e);
    endtask

    task automatic cycle(input bit start, input bit redir, input logic [29:0] addr, input int pop_pct);
        bit restart;
        bit hold_now;
        bit exp_req;
        bit exp_abort;
        @(negedge clk);
        rst_n          = 1'b1;
        restart        = start | redir;
        fetch_start    = start;
        fetch_redirect = redir;
        fetch_addr     = addr;
        ins_pop        = !restart && ($urandom_range(99) < pop_pct);
        hold_now       = 1'b0;
        if (outstanding) begin
            hold_now = (hold_left > 0);
            hold     = hold_now;
            rdv      = (hold_now || bad_rsp) ? 2'b00 : 2'b11;
            rdbus    = {mem_word(line), mem_word(line | 30'd1)};
        end else begin
            hold  = 1'b0;
            rdv   = stale ? 2'b11 : 2'b00;
            rdbus = {$urandom, $urandom};
        end
        stale = 0;
        #1;
        exp_req   = active && !outstanding && !restart && (DEPTH - q.size() >= 2);
        exp_abort = outstanding && (restart || (hold_now && hold_seen == HT));
        check("req_pending", {req, icu, xlate}, {3{exp_req}});
        if (exp_req) check("abus", abus, next_addr);
        check("abort", abort, exp_abort);
        check("fetch_err", fetch_err, exp_err);
        check("ins_valid", ins_valid, q.size() != 0);
        check("tied_zero", {ctx, u0, cache}, 3'b000);
        if (req) req_seen++;

        if (restart) begin
            q.delete();
            active      = 1;
            outstanding = 0;
            next_addr   = addr;
            exp_err     = 0;
        end else if (outstanding) begin
            if (hold_now) begin
                hold_seen++;
                hold_left--;
                if (hold_seen > HT) begin
                    outstanding = 0;
                    active      = 0;
                    exp_err     = 1;
                end
            end else if (bad_rsp) begin
                outstanding = 0;
                active      = 0;
                exp_err     = 1;
            end else begin
                push_exp(next_addr);
                if (next_addr % 2 == 0) push_exp(30'(next_addr + 30'd1));
                next_addr   = 30'((next_addr | 30'd1) + 30'd1);
                outstanding = 0;
            end
        end else if (exp_req) begin
            outstanding = 1;
            line        = abus & ~30'd1;
            hold_seen   = 0;
            bad_rsp     = (hold_mode == 3);
            case (hold_mode)
                1:       hold_left = $urandom_range(3);
                2:       hold_left = 1000;
                default: hold_left = 0;
            endcase
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n          = 1'b0;
            fetch_start    = 1'b0;
            fetch_redirect = 1'b0;
            ins_pop        = 1'b0;
            hold           = 1'b0;
            rdv            = 2'b11;
            #1;
            check("rst_req", {req, icu, xlate, abort}, 4'b0000);
            check("rst_abus", abus, 30'd0);
            check("rst_ins", {ins_valid, ins_data, ins_addr}, '0);
            check("rst_err", fetch_err, 1'b0);
`ifndef ISOCM_FETCH_PERF_EN
            check("rst_perf", {perf_req, perf_hold}, 32'd0);
`endif
        end
        q.delete();
        active      = 0;
        outstanding = 0;
        exp_err     = 0;
        stale       = 1;
    endtask

    // Monitor: every word the consumer takes must be the next one the model predicts.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && ins_valid && ins_pop) begin
                if (q.size() == 0) begin
                    check("pop_unexpected", {ins_addr, ins_data}, '0);
                end else begin
                    e = q.pop_front();
                    check("ins_addr", ins_addr, e.a);
                    check("ins_data", ins_data, e.d);
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        fetch_start    = 1'b0;
        fetch_redirect = 1'b0;
        fetch_addr     = '0;
        ins_pop        = 1'b0;
        hold           = 1'b0;
        rdv            = 2'b00;
        rdbus          = '0;
        do_reset(3);

        // Aligned start with an ideal responder.
        hold_mode = 0;
        cycle(1, 0, 30'h10, 100);
        for (int i = 0; i < 12; i++) cycle(0, 0, '0, 100);

        // Odd start: only the high word of the first line.
        cycle(1, 0, 30'h21, 50);
        for (int i = 0; i < 12; i++) cycle(0, 0, '0, 50);

        // Consumer stalled: two requests fill the buffer, then fetching stalls.
        req_seen = 0;
        cycle(1, 0, 30'h40, 0);
        for (int i = 0; i < 11; i++) cycle(0, 0, '0, 0);
        check("stall_req_count", req_seen, 2);
        for (int i = 0; i < 12; i++) cycle(0, 0, '0, 100);

        // Hold timeout, idle in ERR, then restart clears the error.
        hold_mode = 2;
        cycle(1, 0, 30'h300, 100);
        for (int i = 0; i < 24; i++) cycle(0, 0, '0, 100);
        hold_mode = 0;
        cycle(1, 0, 30'h310, 100);
        for (int i = 0; i < 6; i++) cycle(0, 0, '0, 100);

        // Empty response is an error.
        hold_mode = 3;
        cycle(1, 0, 30'h400, 100);
        for (int i = 0; i < 5; i++) cycle(0, 0, '0, 100);
        hold_mode = 0;
        cycle(0, 1, 30'h408, 100);
        for (int i = 0; i < 6; i++) cycle(0, 0, '0, 100);

        // Redirect during WAIT with the reply present: flushed and discarded.
        cycle(1, 0, 30'h200, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 0);
        cycle(0, 1, 30'h100, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, '0, 100);

        // Address wrap-around from both alignments.
        cycle(1, 0, 30'h3FFF_FFFE, 100);
        for (int i = 0; i < 8; i++) cycle(0, 0, '0, 100);
        cycle(1, 0, 30'h3FFF_FFFF, 100);
        for (int i = 0; i < 8; i++) cycle(0, 0, '0, 100);

        // Reset while a request is held, stale reply after release.
        hold_mode = 2;
        cycle(1, 0, 30'h500, 100);
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 100);
        do_reset(2);
        hold_mode = 0;
        cycle(0, 0, '0, 100);
        cycle(1, 0, 30'h600, 100);
        for (int i = 0; i < 8; i++) cycle(0, 0, '0, 100);

        // Random holds, pops and redirects.
        hold_mode = 1;
        for (int i = 0; i < 400; i++) begin
            logic [29:0] ra;
            bit          rs;
            bit          rr;
            ra = ($urandom_range(3) == 0) ? 30'(30'h3FFF_FFFC + 30'($urandom_range(3)))
                                          : 30'($urandom);
            rs = ($urandom_range(99) < 2);
            rr = !rs && ($urandom_range(99) < 4);
            cycle(rs, rr, ra, $urandom_range(100));
        end
        hold_mode = 0;
        for (int i = 0; i < 20; i++) cycle(0, 0, '0, 100);
`ifndef ISOCM_FETCH_PERF_EN
        check("perf_tied", {perf_req, perf_hold}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
